zip_region_decode: RTL and testbench
====================================

// Module: zip_region_decode
// PURPOSE
//  Parametrised, run-time programmable address-attribute decoder; replaces the
//  fixed SDRAM/FLASH/BKRAM cachable check. Holds NREGIONS addr/mask/attr entries,
//  decodes one address per cycle through a registered valid/ready stage, and
//  returns hit, region index, cachable and writable. Sits between CPU LSU/pfetch
//  and dcache/icache; programmed by a small config write port.
// PARAMETERS
//  ADDRESS_WIDTH  30                 AW, word-address width
//  NREGIONS       4                  table entries, 1..16
//  IW             2                  region index width, $clog2(NREGIONS), min 1
//  INIT_ADDR      {..,30'h4000000}   NREGIONS*AW packed reset bases, entry 0 in LSBs
//  INIT_MASK      {..,30'h4000000}   NREGIONS*AW packed reset masks
//  INIT_ATTR      {..,3'b011}        NREGIONS*3 reset attrs {wr,cache,en}; others 0
// PORTS
//  i_clk        in   1   clock
//  i_reset_n    in   1   async active-low reset
//  i_valid      in   1   lookup request
//  o_ready      out  1   lookup accepted when i_valid && o_ready
//  i_addr       in   AW  lookup address
//  o_valid      out  1   result valid
//  i_ready      in   1   consumer accepts result
//  o_hit        out  1   some enabled region matched
//  o_region     out  IW  index of matching region (0 on miss)
//  o_cachable   out  1   attr cache bit of match, 0 on miss
//  o_writable   out  1   attr wr bit of match, 0 on miss
//  i_cfg_we     in   1   table write strobe
//  i_cfg_idx    in   IW  entry to write
//  i_cfg_addr   in   AW  new base
//  i_cfg_mask   in   AW  new mask
//  i_cfg_attr   in   3   new {wr,cache,en}
//  o_cfg_err    out  1   1-cycle pulse: write rejected
// BEHAVIOUR
//  - Reset (async assert, sync release): table <= INIT_*; o_valid,o_hit,
//    o_region,o_cachable,o_writable,o_cfg_err <= 0.
//  - Match(k): en[k] && ((i_addr & mask[k]) == addr[k]); base 0 legal if en=1.
//  - Priority: lowest matching index wins; miss -> hit=0, region=0, attrs=0.
//  - Latency 1: accepted request at edge N gives o_valid with result after N.
//  - o_ready = !o_valid || i_ready (combinational); while o_valid && !i_ready
//    all outputs hold stable. Accept+drain same cycle -> o_valid stays 1, new data.
//  - No accept and i_ready -> o_valid <= 0.
//  - Config write takes effect at edge; a lookup accepted in the same cycle
//    decodes against the OLD table; next-cycle lookups see the new entry.
//  - i_cfg_idx >= NREGIONS: write dropped, o_cfg_err pulses next cycle.
//  - Held (stalled) result not re-decoded after a table write.
//  - Reset mid-stall: result discarded, o_valid 0, table back to INIT_*.
// CONFIGURATION
//  REGION_LOCK_EN defined: attr gains bit 3 'lock' (cfg attr port 4 bits,
//    INIT_ATTR NREGIONS*4); once an entry is written/reset with lock=1,
//    further writes to it are dropped with o_cfg_err pulse; cleared only by reset.
//  Undefined: attr 3 bits, all entries always writable; lock logic absent.
// TESTING
//  1 Reset defaults, lookup 30'h4000010 -> next cycle o_valid=1,hit=1,region=0,
//    cachable=1,writable=0; lookup 30'h0000010 -> hit=0, all attrs 0.
//  2 Write idx1 base 30'h1000000 mask 30'h3000000 attr 3'b111, then lookup
//    30'h1000004 -> region=1,cachable=1,writable=1; same-cycle lookup -> miss.
//  3 Overlap: idx0 and idx2 both match 30'h4000000 -> region=0 reported.
//  4 Stall: i_ready=0 for 3 cycles with o_valid=1 -> o_ready=0, outputs frozen;
//    back-to-back stream with i_ready=1 -> one result per cycle, no loss.
//  5 NREGIONS=3, write idx 3 -> table unchanged, o_cfg_err=1 for 1 cycle.
//  6 REGION_LOCK_EN: write idx1 with lock=1, rewrite idx1 -> dropped, o_cfg_err;
//    assert i_reset_n=0 mid-stall -> o_valid 0 same cycle, table restored.

Source files
------------

// File: rtl/zip_region_decode.sv
// Programmable address-attribute decoder with a registered valid/ready result stage.
// Define REGION_LOCK_EN to add a per-entry lock bit (attr bit 3) that blocks rewrites.
module zip_region_decode #(
    parameter int ADDRESS_WIDTH = 30,
    parameter int NREGIONS      = 4,
    parameter int IW            = (NREGIONS > 1) ? $clog2(NREGIONS) : 1,
    parameter logic [NREGIONS*ADDRESS_WIDTH-1:0] INIT_ADDR =
        {{(NREGIONS*ADDRESS_WIDTH-1){1'b0}}, 1'b1} << 26,
    parameter logic [NREGIONS*ADDRESS_WIDTH-1:0] INIT_MASK =
        {{(NREGIONS*ADDRESS_WIDTH-1){1'b0}}, 1'b1} << 26,
`ifdef REGION_LOCK_EN
    parameter logic [NREGIONS*4-1:0] INIT_ATTR =
        {{(NREGIONS*4-2){1'b0}}, 2'b11}
`else
    parameter logic [NREGIONS*3-1:0] INIT_ATTR =
        {{(NREGIONS*3-2){1'b0}}, 2'b11}
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_hit,
    output logic [IW-1:0]            o_region,
    output logic                     o_cachable,
    output logic                     o_writable,
    input  logic                     i_cfg_we,
    input  logic [IW-1:0]            i_cfg_idx,
    input  logic [ADDRESS_WIDTH-1:0] i_cfg_addr,
    input  logic [ADDRESS_WIDTH-1:0] i_cfg_mask,
`ifdef REGION_LOCK_EN
    input  logic [3:0]               i_cfg_attr,
`else
    input  logic [2:0]               i_cfg_attr,
`endif
    output logic                     o_cfg_err
);

    localparam int AW = ADDRESS_WIDTH;
`ifdef REGION_LOCK_EN
    localparam int AT = 4;
`else
    localparam int AT = 3;
`endif

    logic [AW-1:0] base_q [NREGIONS];
    logic [AW-1:0] base_d [NREGIONS];
    logic [AW-1:0] mask_q [NREGIONS];
    logic [AW-1:0] mask_d [NREGIONS];
    logic [AT-1:0] attr_q [NREGIONS];
    logic [AT-1:0] attr_d [NREGIONS];

    logic          valid_q, valid_d;
    logic          hit_q, hit_d;
    logic [IW-1:0] region_q, region_d;
    logic          cache_q, cache_d;
    logic          wr_q, wr_d;
    logic          cfg_err_q, cfg_err_d;

    logic          accept;
    logic          dec_hit;
    logic [IW-1:0] dec_region;
    logic          dec_cache;
    logic          dec_wr;
    logic          idx_ok;
    logic          locked;
    logic          wr_ok;

    assign o_ready    = !valid_q || i_ready;
    assign accept     = i_valid && o_ready;
    assign o_valid    = valid_q;
    assign o_hit      = hit_q;
    assign o_region   = region_q;
    assign o_cachable = cache_q;
    assign o_writable = wr_q;
    assign o_cfg_err  = cfg_err_q;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit    = 1'b0;
        dec_region = '0;
        dec_cache  = 1'b0;
        dec_wr     = 1'b0;
        for (int k = NREGIONS - 1; k >= 0; k--) begin
            if (attr_q[k][0] && ((i_addr & mask_q[k]) == base_q[k])) begin
                dec_hit    = 1'b1;
                dec_region = IW'(k);
                dec_cache  = attr_q[k][1];
                dec_wr     = attr_q[k][2];
            end
        end
    end

    always_comb begin
        idx_ok = 1'b0;
        locked = 1'b0;
        for (int k = 0; k < NREGIONS; k++) begin
            if (i_cfg_idx == IW'(k)) begin
                idx_ok = 1'b1;
`ifdef REGION_LOCK_EN
                locked = attr_q[k][3];
`endif
            end
        end
        wr_ok     = i_cfg_we && idx_ok && !locked;
        cfg_err_d = i_cfg_we && !wr_ok;
        for (int k = 0; k < NREGIONS; k++) begin
            base_d[k] = base_q[k];
            mask_d[k] = mask_q[k];
            attr_d[k] = attr_q[k];
            if (wr_ok && (i_cfg_idx == IW'(k))) begin
                base_d[k] = i_cfg_addr;
                mask_d[k] = i_cfg_mask;
                attr_d[k] = i_cfg_attr;
            end
        end
    end

    always_comb begin
        valid_d  = accept || (valid_q && !i_ready);
        hit_d    = hit_q;
        region_d = region_q;
        cache_d  = cache_q;
        wr_d     = wr_q;
        if (accept) begin
            hit_d    = dec_hit;
            region_d = dec_region;
            cache_d  = dec_cache;
            wr_d     = dec_wr;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NREGIONS; k++) begin
                base_q[k] <= INIT_ADDR[k*AW +: AW];
                mask_q[k] <= INIT_MASK[k*AW +: AW];
                attr_q[k] <= INIT_ATTR[k*AT +: AT];
            end
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            region_q  <= '0;
            cache_q   <= 1'b0;
            wr_q      <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NREGIONS; k++) begin
                base_q[k] <= base_d[k];
                mask_q[k] <= mask_d[k];
                attr_q[k] <= attr_d[k];
            end
            valid_q   <= valid_d;
            hit_q     <= hit_d;
            region_q  <= region_d;
            cache_q   <= cache_d;
            wr_q      <= wr_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_zip_region_decode.sv
// Directed bench for zip_region_decode: default 4-entry instance plus a
// 3-entry instance for the out-of-range config index case.
module tb_zip_region_decode;

`ifdef REGION_LOCK_EN
    localparam int AT = 4;
`else
    localparam int AT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid, i_ready, cfg_we;
    logic [29:0]   i_addr, cfg_addr, cfg_mask;
    logic [1:0]    cfg_idx;
    logic [AT-1:0] cfg_attr;
    logic          o_ready, o_valid, o_hit, o_cachable, o_writable, o_cfg_err;
    logic [1:0]    o_region;
    logic [5:0]    res;

    logic          d3_valid, d3_iready, d3_we;
    logic [29:0]   d3_addr, d3_caddr, d3_cmask;
    logic [1:0]    d3_idx;
    logic [AT-1:0] d3_attr;
    logic          d3_ready, d3_ovalid, d3_hit, d3_cache, d3_wr, d3_err;
    logic [1:0]    d3_region;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    assign res = {o_valid, o_hit, o_region, o_cachable, o_writable};

    zip_region_decode dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_addr(i_addr),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_hit(o_hit), .o_region(o_region),
        .o_cachable(o_cachable), .o_writable(o_writable),
        .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx),
        .i_cfg_addr(cfg_addr), .i_cfg_mask(cfg_mask),
        .i_cfg_attr(cfg_attr), .o_cfg_err(o_cfg_err)
    );

    zip_region_decode #(.NREGIONS(3)) dut3 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_valid(d3_valid), .o_ready(d3_ready), .i_addr(d3_addr),
        .o_valid(d3_ovalid), .i_ready(d3_iready),
        .o_hit(d3_hit), .o_region(d3_region),
        .o_cachable(d3_cache), .o_writable(d3_wr),
        .i_cfg_we(d3_we), .i_cfg_idx(d3_idx),
        .i_cfg_addr(d3_caddr), .i_cfg_mask(d3_cmask),
        .i_cfg_attr(d3_attr), .o_cfg_err(d3_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // attr given as {lock,wr,cache,en}; lock is dropped in the 3-bit build
    task automatic cfg(input logic we, input logic [1:0] idx,
                       input logic [29:0] b, input logic [29:0] m,
                       input logic [3:0] a);
        cfg_we   = we;
        cfg_idx  = idx;
        cfg_addr = b;
        cfg_mask = m;
        cfg_attr = a[AT-1:0];
    endtask

    task automatic look(input logic v, input logic [29:0] a);
        i_valid = v;
        i_addr  = a;
    endtask

    initial begin
        rst_n = 1'b0;
        i_ready = 1'b1;
        look(1'b0, '0);
        cfg(1'b0, 2'd0, '0, '0, 4'b0000);
        d3_valid = 1'b0; d3_iready = 1'b1; d3_addr = '0;
        d3_we = 1'b0; d3_idx = '0; d3_caddr = '0; d3_cmask = '0;
        d3_attr = '0;
        #1;
        chk("reset_res", 32'(res), 32'h0);
        chk("reset_err", 32'(o_cfg_err), 32'h0);
        chk("reset_rdy", 32'(o_ready), 32'h1);
        chk("reset_d3err", 32'(d3_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        look(1'b1, 30'h4000010);
        tick();
        chk("t1_hit0", 32'(res), 32'h32);
        look(1'b1, 30'h0000010);
        tick();
        chk("t1_miss", 32'(res), 32'h20);
        look(1'b0, '0);
        tick();
        chk("t1_idle", 32'(o_valid), 32'h0);

        cfg(1'b1, 2'd1, 30'h1000000, 30'h3000000, 4'b0111);
        look(1'b1, 30'h1000004);
        tick();
        chk("t2_oldtbl", 32'(res), 32'h20);
        chk("t2_noerr", 32'(o_cfg_err), 32'h0);
        cfg(1'b0, 2'd0, '0, '0, 4'b0000);
        tick();
        chk("t2_newtbl", 32'(res), 32'h37);

        look(1'b0, '0);
        cfg(1'b1, 2'd2, 30'h4000000, 30'h3FFFFFFF, 4'b0101);
        tick();
        cfg(1'b0, 2'd0, '0, '0, 4'b0000);
        look(1'b1, 30'h4000000);
        tick();
        chk("t3_overlap", 32'(res), 32'h32);
        look(1'b0, '0);
        cfg(1'b1, 2'd0, 30'h4000000, 30'h4000000, 4'b0000);
        tick();
        cfg(1'b1, 2'd3, 30'h0, 30'h0, 4'b0001);
        tick();
        cfg(1'b0, 2'd0, '0, '0, 4'b0000);
        look(1'b1, 30'h4000000);
        tick();
        chk("t3_idx2", 32'(res), 32'h39);
        look(1'b1, 30'h0000010);
        tick();
        chk("t3_base0", 32'(res), 32'h3C);

        look(1'b1, 30'h1000004);
        tick();
        chk("t4_first", 32'(res), 32'h37);
        i_ready = 1'b0;
        look(1'b1, 30'h0000010);
        cfg(1'b1, 2'd1, 30'h1000000, 30'h3000000, 4'b0000);
        #1;
        chk("t4_nordy", 32'(o_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            cfg(1'b0, 2'd0, '0, '0, 4'b0000);
            chk("t4_hold", 32'(res), 32'h37);
            chk("t4_hold_rdy", 32'(o_ready), 32'h0);
        end
        i_ready = 1'b1;
        #1;
        chk("t4_rdy", 32'(o_ready), 32'h1);
        tick();
        chk("t4_drain", 32'(res), 32'h3C);
        look(1'b1, 30'h4000000);
        tick();
        chk("t4_s0", 32'(res), 32'h39);
        look(1'b1, 30'h0000010);
        tick();
        chk("t4_s1", 32'(res), 32'h3C);
        look(1'b1, 30'h4000000);
        tick();
        chk("t4_s2", 32'(res), 32'h39);
        look(1'b0, '0);
        tick();
        chk("t4_end", 32'(o_valid), 32'h0);

        d3_we = 1'b1; d3_idx = 2'd3; d3_caddr = '0; d3_cmask = '0;
        d3_attr = AT'(4'b0001);
        tick();
        chk("t5_err", 32'(d3_err), 32'h1);
        d3_we = 1'b0;
        tick();
        chk("t5_pulse", 32'(d3_err), 32'h0);
        d3_valid = 1'b1; d3_addr = 30'h0000010;
        tick();
        chk("t5_unchg", 32'({d3_ovalid, d3_hit, d3_region}), 32'h8);
        d3_valid = 1'b0;

`ifdef REGION_LOCK_EN
        cfg(1'b1, 2'd1, 30'h1000000, 30'h3000000, 4'b1111);
        tick();
        chk("t6_lockwr", 32'(o_cfg_err), 32'h0);
        cfg(1'b1, 2'd1, 30'h0, 30'h0, 4'b0000);
        tick();
        chk("t6_lockerr", 32'(o_cfg_err), 32'h1);
        cfg(1'b0, 2'd0, '0, '0, 4'b0000);
        look(1'b1, 30'h1000004);
        tick();
        chk("t6_lockpulse", 32'(o_cfg_err), 32'h0);
        chk("t6_kept", 32'(res), 32'h37);
`endif

        look(1'b1, 30'h4000000);
        tick();
        chk("t6_pre", 32'(res), 32'h39);
        look(1'b0, '0);
        i_ready = 1'b0;
        tick();
        chk("t6_stall", 32'(res), 32'h39);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rstnow", 32'(res), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 1'b1;
        look(1'b1, 30'h4000000);
        tick();
        chk("t6_init0", 32'(res), 32'h32);
        look(1'b1, 30'h1000004);
        tick();
        chk("t6_init1", 32'(res), 32'h20);
        look(1'b0, '0);

`ifdef REGION_LOCK_EN
        cfg(1'b1, 2'd1, 30'h1000000, 30'h3000000, 4'b0111);
        tick();
        chk("t6_unlock", 32'(o_cfg_err), 32'h0);
        cfg(1'b0, 2'd0, '0, '0, 4'b0000);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
